fpu_result_uart_tx: RTL and testbench

FPU_RESULT_UART_TX -- requirements
Module: fpu_result_uart_tx

---
 rtl/fpu_result_uart_tx.sv | 80 ++++++++
 tb/tb_fpu_result_uart_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fpu_result_uart_tx.sv
// fpu_result_uart_tx: sends a 16-bit FPU result as two back-to-back 8N1 UART bytes, low byte first.
module fpu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tx_valid,
  input  logic [15:0] i_tx_data,
  output logic        o_tx_ready,
  output logic        o_tx_serial,
  output logic        o_tx_active,
  output logic        o_tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic byte_sel, byte_sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [15:0] hold, hold_n;
  logic [7:0] cur_byte;
  logic serial_n, done_n, tick;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_sel    <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      hold        <= '0;
      o_tx_serial <= 1'b1;
      o_tx_done   <= 1'b0;
    end else begin
      state       <= state_n;
      byte_sel    <= byte_sel_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      hold        <= hold_n;
      o_tx_serial <= serial_n;
      o_tx_done   <= done_n;
    end
  end
  always_comb begin
    tick       = cnt == CW'(CLKS_PER_BIT - 1);
    state_n    = state;
    byte_sel_n = byte_sel;
    cnt_n      = tick ? '0 : cnt + 1'b1;
    bit_idx_n  = bit_idx;
    hold_n     = hold;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_tx_valid) begin
          state_n    = START;
          byte_sel_n = 1'b0;
          hold_n     = i_tx_data;
        end
      end
      START: if (tick) begin
        state_n   = DATA;
        bit_idx_n = '0;
      end
      DATA: if (tick) begin
        bit_idx_n = bit_idx + 3'd1;
        state_n   = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_n    = byte_sel ? IDLE : START;
        byte_sel_n = 1'b1;
        done_n     = byte_sel;
      end
      default: state_n = IDLE;
    endcase
    // The line register is loaded with the bit belonging to the state being entered.
    cur_byte = byte_sel_n ? hold_n[15:8] : hold_n[7:0];
    serial_n = state_n == START ? 1'b0 : state_n == DATA ? cur_byte[bit_idx_n] : 1'b1;
  end
  assign o_tx_ready  = state == IDLE;
  assign o_tx_active = state != IDLE;
endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// tb_fpu_result_uart_tx: directed checks of framing, timing, busy behaviour and reset.
module tb_fpu_result_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_tx_valid = 1'b0;
  logic [15:0] i_tx_data = '0;
  logic o_tx_ready, o_tx_serial, o_tx_active, o_tx_done;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;
  int done_gap = 0;

  fpu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .i_tx_valid(i_tx_valid),
    .i_tx_data(i_tx_data),
    .o_tx_ready(o_tx_ready),
    .o_tx_serial(o_tx_serial),
    .o_tx_active(o_tx_active),
    .o_tx_done(o_tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_tx_done) begin
    done_cnt  <= done_cnt + 1;
    done_gap  <= cyc - last_done;
    last_done <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] frame(input logic [15:0] w);
    return {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
  endfunction

  // Offer w while idle; returns in cycle T+1 with i_tx_valid still high.
  task automatic accept(input logic [15:0] w);
    chk("ready_before_accept", o_tx_ready, 1'b1);
    i_tx_valid = 1'b1;
    i_tx_data  = w;
    step();
  endtask

  // Entered in cycle T+1, leaves in the done cycle T+81.
  task automatic check_frame(input logic [15:0] w, input bit noise);
    logic [19:0] f;
    f = frame(w);
    for (int j = 1; j <= 20 * CPB; j++) begin
      if (noise) begin
        i_tx_valid = (j < 70) ? j[0] : 1'b0;
        i_tx_data  = 16'(j * 16'h1357);
      end
      chk("active_nodone", {30'd0, o_tx_active, o_tx_done}, 32'b10);
      chk("ready_busy", o_tx_ready, 1'b0);
      if ((j - 1) % CPB == 1) chk($sformatf("bit%0d", (j - 1) / CPB), o_tx_serial, f[(j - 1) / CPB]);
      step();
    end
    chk("done_cycle", {29'd0, o_tx_done, o_tx_ready, o_tx_active}, 32'b110);
    chk("done_line_high", o_tx_serial, 1'b1);
  endtask

  initial begin
    int d0;
    i_tx_valid = 1'b1;
    i_tx_data  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_state", {28'd0, o_tx_serial, o_tx_ready, o_tx_active, o_tx_done}, 32'b1100);
    end
    rst = 1'b0;
    i_tx_valid = 1'b0;
    step();
    step();
    chk("rst_no_frame", {30'd0, o_tx_active, o_tx_serial}, 32'b01);

    accept(16'h3C00);
    i_tx_valid = 1'b0;
    check_frame(16'h3C00, 1'b0);
    step();
    chk("single_done_once", {31'd0, o_tx_done}, 32'd0);
    chk("single_done_cnt", done_cnt, 1);

    accept(16'hA55A);
    i_tx_valid = 1'b0;
    check_frame(16'hA55A, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("busy_no_second", {30'd0, o_tx_active, o_tx_ready}, 32'b01);
    chk("busy_done_cnt", done_cnt, 2);

    accept(16'hFFFF);
    i_tx_data = 16'h0001;
    check_frame(16'hFFFF, 1'b0);
    step();
    i_tx_valid = 1'b0;
    chk("b2b_start_T82", {31'd0, o_tx_serial}, 32'd0);
    check_frame(16'h0001, 1'b0);
    step();
    chk("b2b_done_cnt", done_cnt, 4);
    chk("b2b_done_gap", done_gap, 81);

    accept(16'h0000);
    i_tx_valid = 1'b0;
    for (int i = 0; i < 25; i++) step();
    chk("mid_bit5_low", {30'd0, o_tx_active, o_tx_serial}, 32'b10);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    chk("mid_rst_state", {28'd0, o_tx_serial, o_tx_ready, o_tx_active, o_tx_done}, 32'b1100);
    rst = 1'b0;
    for (int i = 0; i < 90; i++) step();
    chk("mid_rst_no_done", done_cnt, d0);
    accept(16'h1234);
    i_tx_valid = 1'b0;
    check_frame(16'h1234, 1'b0);
    step();
    chk("after_rst_done_cnt", done_cnt, d0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
